// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the IF/D memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned MPA_DATA_WIDTH   = 32;
    localparam int unsigned MPA_ADDR_WIDTH   = 32;
    localparam int unsigned MPA_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } mpa_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } mpa_owner_e;

endpackage

// File: rtl/mpa_prio_pick.sv
// Winner select between fetch and data requesters, with the fetch anti-starvation counter.
module mpa_prio_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = MPA_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic if_valid,
    input  logic d_valid,
    input  logic take,
    output logic grant_d
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_LIMIT));
    assign grant_d = d_valid && !(if_valid && starved);

    // Counts fetch losses; cleared whenever fetch is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (take && if_valid) begin
            if (!grant_d)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (D), one transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = MPA_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = MPA_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT = MPA_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_rdata,
    input  logic                    d_req_valid,
    input  logic                    d_req_we,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    output logic                    d_req_ready,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_rdata,
    output logic                    m_req_valid,
    input  logic                    m_req_ready,
    output logic                    m_req_we,
    output logic [ADDR_WIDTH-1:0]   m_req_addr,
    output logic [DATA_WIDTH-1:0]   m_req_wdata,
    output logic [DATA_WIDTH/8-1:0] m_req_wstrb,
    input  logic                    m_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   m_rsp_rdata,
    output logic                    busy,
    output logic                    protocol_err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    mpa_state_e              state, state_nxt;
    mpa_owner_e              owner;
    logic                    cmd_we;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [STRB_WIDTH-1:0]   cmd_wstrb;
    logic                    grant_d;
    logic                    take;

    // Arbitration is suppressed while reset is held so no ready leaks out.
    assign take = reset && (state == ST_IDLE) && (if_req_valid || d_req_valid);

    mpa_prio_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .take     (take),
        .grant_d  (grant_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (take)        state_nxt = ST_ISSUE;
            ST_ISSUE: if (m_req_ready) state_nxt = ST_WAIT;
            ST_WAIT:  if (m_rsp_valid) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Command is captured once at acceptance and ignores later requester activity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWN_IF;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_wstrb <= '0;
        end else if (take) begin
            if (grant_d) begin
                owner     <= OWN_D;
                cmd_we    <= d_req_we;
                cmd_addr  <= d_req_addr;
                cmd_wdata <= d_req_wdata;
                cmd_wstrb <= d_req_wstrb;
            end else begin
                owner     <= OWN_IF;
                cmd_we    <= 1'b0;
                cmd_addr  <= if_req_addr;
                cmd_wdata <= '0;
                cmd_wstrb <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            protocol_err <= 1'b0;
        else if (m_rsp_valid && (state != ST_WAIT))
            protocol_err <= 1'b1;
    end

    always_comb begin
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_rdata = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_rdata  = '0;
        m_req_valid  = 1'b0;
        m_req_we     = 1'b0;
        m_req_addr   = '0;
        m_req_wdata  = '0;
        m_req_wstrb  = '0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (reset) begin
                    d_req_ready  = grant_d;
                    if_req_ready = if_req_valid && !grant_d;
                end
            end
            ST_ISSUE: begin
                m_req_valid = 1'b1;
                m_req_we    = cmd_we;
                m_req_addr  = cmd_addr;
                m_req_wdata = cmd_wdata;
                m_req_wstrb = cmd_wstrb;
            end
            ST_WAIT: begin
                if (m_rsp_valid) begin
                    if (owner == OWN_D) begin
                        d_rsp_valid = 1'b1;
                        d_rsp_rdata = cmd_we ? '0 : m_rsp_rdata;
                    end else begin
                        if_rsp_valid = 1'b1;
                        if_rsp_rdata = m_rsp_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a protocol model.
module tb_mem_port_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned SW    = DW / 8;
    localparam int          LIMIT = 4;

    logic          clk;
    logic          reset;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_rdata;
    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic [SW-1:0] d_req_wstrb;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_rdata;
    logic          m_req_valid;
    logic          m_req_ready;
    logic          m_req_we;
    logic [AW-1:0] m_req_addr;
    logic [DW-1:0] m_req_wdata;
    logic [SW-1:0] m_req_wstrb;
    logic          m_rsp_valid;
    logic [DW-1:0] m_rsp_rdata;
    logic          busy;
    logic          protocol_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_rdata (if_rsp_rdata),
        .d_req_valid  (d_req_valid),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_wstrb  (d_req_wstrb),
        .d_req_ready  (d_req_ready),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_rdata  (d_rsp_rdata),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_we     (m_req_we),
        .m_req_addr   (m_req_addr),
        .m_req_wdata  (m_req_wdata),
        .m_req_wstrb  (m_req_wstrb),
        .m_rsp_valid  (m_rsp_valid),
        .m_rsp_rdata  (m_rsp_rdata),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        d_req_addr   = '0;
        d_req_wdata  = '0;
        d_req_wstrb  = '0;
        m_req_ready  = 1'b0;
        m_rsp_valid  = 1'b0;
        m_rsp_rdata  = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset        = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h10;
        d_req_valid  = 1'b1;
        d_req_addr   = 32'h20;
        tick();
        tick();
        n_tests++; if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready got=%b exp=0", if_req_ready); end
        n_tests++; if (d_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_d_ready got=%b exp=0", d_req_ready); end
        n_tests++; if (m_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%b exp=0", m_req_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_tests++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL rst_perr got=%b exp=0", protocol_err); end
        n_tests++; if ({if_rsp_rdata, d_rsp_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", {if_rsp_rdata, d_rsp_rdata}); end
        reset = 1'b1;
        #1;
        n_tests++; if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_first_grant got d=%b if=%b exp d=1 if=0", d_req_ready, if_req_ready); end
        tick();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        m_req_ready  = 1'b1;
        #1;
        n_tests++; if (m_req_valid !== 1'b1 || m_req_addr !== 32'h20) begin n_fail++; $display("FAIL rst_first_cmd got v=%b a=%h exp v=1 a=20", m_req_valid, m_req_addr); end
        tick();
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'hA1B2C3D4;
        #1;
        n_tests++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL rst_first_rsp got v=%b d=%h exp v=1 d=a1b2c3d4", d_rsp_valid, d_rsp_rdata); end
        tick();
        m_rsp_valid = 1'b0;
    endtask

    task automatic test_single_if();
        apply_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        #1;
        n_tests++; if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin n_fail++; $display("FAIL if_grant got if=%b d=%b exp if=1 d=0", if_req_ready, d_req_ready); end
        tick();
        if_req_valid = 1'b0;
        m_req_ready  = 1'b1;
        #1;
        n_tests++; if ({m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb} !== {1'b1, 1'b0, 32'h40, 32'h0, 4'h0}) begin
            n_fail++; $display("FAIL if_cmd got v=%b we=%b a=%h wd=%h ws=%h exp v=1 we=0 a=40 wd=0 ws=0", m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb); end
        n_tests++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL if_early_rsp got=%b exp=0", if_rsp_valid); end
        tick();
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'hDEADBEEF;
        #1;
        n_tests++; if (if_rsp_valid !== 1'b1 || if_rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_rsp got v=%b d=%h exp v=1 d=deadbeef", if_rsp_valid, if_rsp_rdata); end
        n_tests++; if (d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL if_d_rsp got=%b exp=0", d_rsp_valid); end
        tick();
        m_rsp_valid = 1'b0;
        #1;
        n_tests++; if (if_rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL if_after got v=%b busy=%b exp 0 0", if_rsp_valid, busy); end
    endtask

    task automatic test_store_stall();
        apply_reset();
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 32'h100;
        d_req_wdata = 32'h12345678;
        d_req_wstrb = 4'b0011;
        tick();
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_addr  = 32'hFFF;
        d_req_wdata = $urandom;
        d_req_wstrb = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            m_req_ready = (i == 3);
            #1;
            n_tests++; if ({m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb} !== {1'b1, 1'b1, 32'h100, 32'h12345678, 4'b0011}) begin
                n_fail++; $display("FAIL st_cmd[%0d] got v=%b we=%b a=%h wd=%h ws=%h exp v=1 we=1 a=100 wd=12345678 ws=3", i, m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb); end
            tick();
        end
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'hCAFEF00D;
        #1;
        n_tests++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL st_rsp got v=%b d=%h exp v=1 d=0", d_rsp_valid, d_rsp_rdata); end
        n_tests++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL st_if_rsp got=%b exp=0", if_rsp_valid); end
        tick();
        m_rsp_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  starve;
        bit  exp_d;
        logic [DW-1:0] data;
        apply_reset();
        starve       = 0;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        m_req_ready  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if_req_addr = 32'h1000 + 32'(k);
            d_req_addr  = 32'h2000 + 32'(k);
            exp_d = (starve != LIMIT);
            starve = exp_d ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
            #1;
            n_tests++; if (d_req_ready !== exp_d || if_req_ready !== !exp_d) begin
                n_fail++; $display("FAIL b2b_grant[%0d] got d=%b if=%b exp d=%b", k, d_req_ready, if_req_ready, exp_d); end
            tick();
            tick();
            data = $urandom;
            m_rsp_valid = 1'b1;
            m_rsp_rdata = data;
            #1;
            n_tests++; if ((exp_d ? {d_rsp_valid, if_rsp_valid, d_rsp_rdata} : {if_rsp_valid, d_rsp_valid, if_rsp_rdata}) !== {1'b1, 1'b0, data}) begin
                n_fail++; $display("FAIL b2b_rsp[%0d] got dv=%b iv=%b dd=%h id=%h exp owner_d=%b data=%h", k, d_rsp_valid, if_rsp_valid, d_rsp_rdata, if_rsp_rdata, exp_d, data); end
            tick();
            m_rsp_valid = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_protocol_err();
        apply_reset();
        n_tests++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL perr_init got=%b exp=0", protocol_err); end
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'h55AA55AA;
        #1;
        n_tests++; if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL perr_pulse got if=%b d=%b exp 0 0", if_rsp_valid, d_rsp_valid); end
        tick();
        m_rsp_valid = 1'b0;
        #1;
        n_tests++; if (protocol_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL perr_set got perr=%b busy=%b exp 1 0", protocol_err, busy); end
        tick();
        tick();
        n_tests++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got=%b exp=1", protocol_err); end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h80;
        tick();
        if_req_valid = 1'b0;
        m_req_ready  = 1'b1;
        tick();
        m_req_ready = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rw_busy got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0 || if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_reset got busy=%b v=%b exp 0 0", busy, if_rsp_valid); end
        tick();
        reset       = 1'b1;
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'h77777777;
        #1;
        n_tests++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_late_pulse got=%b exp=0", if_rsp_valid); end
        tick();
        m_rsp_valid = 1'b0;
        #1;
        n_tests++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL rw_perr got=%b exp=1", protocol_err); end
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 32'h44;
        #1;
        n_tests++; if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_next_grant got=%b exp=1", d_req_ready); end
        tick();
        d_req_valid = 1'b0;
        m_req_ready = 1'b1;
        #1;
        n_tests++; if (m_req_valid !== 1'b1 || m_req_addr !== 32'h44 || m_req_we !== 1'b0) begin
            n_fail++; $display("FAIL rw_next_cmd got v=%b a=%h we=%b exp v=1 a=44 we=0", m_req_valid, m_req_addr, m_req_we); end
        tick();
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'h0BADCAFE;
        #1;
        n_tests++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'h0BADCAFE) begin n_fail++; $display("FAIL rw_next_rsp got v=%b d=%h exp v=1 d=0badcafe", d_rsp_valid, d_rsp_rdata); end
        tick();
        m_rsp_valid = 1'b0;
    endtask

    // Random traffic: model tracks accepted command, starvation count and the response owed.
    task automatic test_random();
        int            phase;
        int            starve;
        int            rsp_wait;
        bit            e_owner_d, e_we, exp_d, exp_if, acc_if, acc_d;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [SW-1:0] e_wstrb;
        apply_reset();
        phase = 0; starve = 0; rsp_wait = 0;
        e_owner_d = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        acc_if = 1'b0; acc_d = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (acc_if) if_req_valid = 1'b0;
            if (acc_d)  d_req_valid  = 1'b0;
            if (!if_req_valid && $urandom_range(0, 2) == 0) begin
                if_req_valid = 1'b1;
                if_req_addr  = $urandom;
            end
            if (!d_req_valid && $urandom_range(0, 2) == 0) begin
                d_req_valid = 1'b1;
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_addr  = $urandom;
                d_req_wdata = $urandom;
                d_req_wstrb = 4'($urandom);
            end
            m_req_ready = 1'($urandom_range(0, 2) != 0);
            m_rsp_valid = 1'b0;
            m_rsp_rdata = $urandom;
            if (phase == 2) begin
                if (rsp_wait == 0) m_rsp_valid = 1'b1;
                else rsp_wait--;
            end
            #1;
            acc_if = 1'b0; acc_d = 1'b0;
            case (phase)
                0: begin
                    exp_d  = d_req_valid && !(if_req_valid && starve == LIMIT);
                    exp_if = if_req_valid && !exp_d;
                    n_tests++; if (d_req_ready !== exp_d || if_req_ready !== exp_if) begin
                        n_fail++; $display("FAIL rnd_grant[%0d] got d=%b if=%b exp d=%b if=%b", cyc, d_req_ready, if_req_ready, exp_d, exp_if); end
                    n_tests++; if (busy !== 1'b0 || m_req_valid !== 1'b0) begin
                        n_fail++; $display("FAIL rnd_idle[%0d] got busy=%b mv=%b exp 0 0", cyc, busy, m_req_valid); end
                    if (exp_d) begin
                        if (if_req_valid && starve < LIMIT) starve++;
                        e_owner_d = 1'b1; e_we = d_req_we; e_addr = d_req_addr;
                        e_wdata = d_req_wdata; e_wstrb = d_req_wstrb;
                        acc_d = 1'b1; phase = 1;
                    end else if (exp_if) begin
                        starve = 0;
                        e_owner_d = 1'b0; e_we = 1'b0; e_addr = if_req_addr;
                        e_wdata = '0; e_wstrb = '0;
                        acc_if = 1'b1; phase = 1;
                    end
                end
                1: begin
                    n_tests++; if ({m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb} !== {1'b1, e_we, e_addr, e_wdata, e_wstrb}) begin
                        n_fail++; $display("FAIL rnd_cmd[%0d] got v=%b we=%b a=%h wd=%h ws=%h exp we=%b a=%h wd=%h ws=%h", cyc, m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb, e_we, e_addr, e_wdata, e_wstrb); end
                    n_tests++; if (if_req_ready !== 1'b0 || d_req_ready !== 1'b0 || busy !== 1'b1) begin
                        n_fail++; $display("FAIL rnd_issue[%0d] got ifr=%b dr=%b busy=%b exp 0 0 1", cyc, if_req_ready, d_req_ready, busy); end
                    if (m_req_ready) begin
                        phase = 2;
                        rsp_wait = $urandom_range(0, 2);
                    end
                end
                default: begin
                    n_tests++; if (m_req_valid !== 1'b0 || busy !== 1'b1) begin
                        n_fail++; $display("FAIL rnd_wait[%0d] got mv=%b busy=%b exp 0 1", cyc, m_req_valid, busy); end
                    if (m_rsp_valid) begin
                        n_tests++; if ({d_rsp_valid, if_rsp_valid} !== {e_owner_d, !e_owner_d}) begin
                            n_fail++; $display("FAIL rnd_rsp_owner[%0d] got d=%b if=%b exp owner_d=%b", cyc, d_rsp_valid, if_rsp_valid, e_owner_d); end
                        n_tests++; if ((e_owner_d ? d_rsp_rdata : if_rsp_rdata) !== ((e_owner_d && e_we) ? 32'h0 : m_rsp_rdata)) begin
                            n_fail++; $display("FAIL rnd_rsp_data[%0d] got d=%h i=%h exp owner_d=%b we=%b mem=%h", cyc, d_rsp_rdata, if_rsp_rdata, e_owner_d, e_we, m_rsp_rdata); end
                        phase = 0;
                    end else begin
                        n_tests++; if (d_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin
                            n_fail++; $display("FAIL rnd_no_rsp[%0d] got d=%b if=%b exp 0 0", cyc, d_rsp_valid, if_rsp_valid); end
                    end
                end
            endcase
            @(posedge clk);
            #1;
        end
        n_tests++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL rnd_perr got=%b exp=0", protocol_err); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_single_if();
        test_store_stall();
        test_back_to_back();
        test_protocol_err();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
